vector_list_seq: RTL and testbench

//  Display-list sequencer directly upstream of the Bresenham line drawer.
//  On frame_start it walks a list of points in external sync-read memory and

---
 rtl/vector_pkg.sv | 30 +++
 rtl/vector_list_seq.sv | 193 +++++++++++++++++++
 tb/tb_vector_list_seq.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
//------------------------------------------------------------------------------
// Module  : vector_pkg
// Brief   : State encoding and display-list entry field positions for the
//           vector list sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vector_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_GO      = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_WAIT_LO = 3'd5;
    localparam logic [2:0] S_NEXT    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam int ENTRY_W = 18;
    localparam int LAST_B  = 17;
    localparam int MOVE_B  = 16;
    localparam int X_MSB   = 15;
    localparam int X_LSB   = 8;
    localparam int Y_MSB   = 7;
    localparam int Y_LSB   = 0;

endpackage

`default_nettype wire

// File: rtl/vector_list_seq.sv
//------------------------------------------------------------------------------
// Module  : vector_list_seq
// Brief   : Walks a display list in sync-read memory and issues one line per
//           draw entry to the line drawer. Optional watchdog on the drawer
//           handshake is enabled by defining VSEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vector_list_seq
    import vector_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int TMO_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [ENTRY_W-1:0]  mem_data,
    output logic                ld_go,
    input  logic                ld_busy,
    output logic [7:0]          ld_stax,
    output logic [7:0]          ld_stay,
    output logic [7:0]          ld_endx,
    output logic [7:0]          ld_endy,
    output logic                seq_busy,
    output logic                frame_done,
    output logic                tmo_err
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              first_q, first_d;
    logic              last_q,  last_d;
    logic [7:0]        curx_q,  curx_d;
    logic [7:0]        cury_q,  cury_d;
    logic [7:0]        stax_q,  stax_d;
    logic [7:0]        stay_q,  stay_d;
    logic [7:0]        endx_q,  endx_d;
    logic [7:0]        endy_q,  endy_d;
    logic              w_tmo_hit;
    logic              w_in_wait;
    logic [7:0]        w_x;
    logic [7:0]        w_y;

    assign w_x       = mem_data[X_MSB:X_LSB];
    assign w_y       = mem_data[Y_MSB:Y_LSB];
    assign w_in_wait = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        first_d = first_q;
        last_d  = last_q;
        curx_d  = curx_q;
        cury_d  = cury_q;
        stax_d  = stax_q;
        stay_d  = stay_q;
        endx_d  = endx_q;
        endy_d  = endy_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    addr_d  = '0;
                    first_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                last_d = mem_data[LAST_B];
                curx_d = w_x;
                cury_d = w_y;
                // The first entry only places the pen, whatever its move bit says.
                if (mem_data[MOVE_B] || first_q) begin
                    first_d = 1'b0;
                    state_d = S_NEXT;
                end else begin
                    stax_d  = curx_q;
                    stay_d  = cury_q;
                    endx_d  = w_x;
                    endy_d  = w_y;
                    state_d = S_GO;
                end
            end
            S_GO: state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (w_tmo_hit) begin
                    state_d = S_DONE;
                end else if (ld_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (w_tmo_hit) begin
                    state_d = S_DONE;
                end else if (!ld_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_q || (addr_q == '1)) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            curx_q  <= '0;
            cury_q  <= '0;
            stax_q  <= '0;
            stay_q  <= '0;
            endx_q  <= '0;
            endy_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            first_q <= first_d;
            last_q  <= last_d;
            curx_q  <= curx_d;
            cury_q  <= cury_d;
            stax_q  <= stax_d;
            stay_q  <= stay_d;
            endx_q  <= endx_d;
            endy_q  <= endy_d;
        end
    end

`ifdef VSEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q;

    assign w_tmo_hit = w_in_wait && (tmo_cnt_q == '1);

    // Counter restarts whenever the state moves, so each wait phase is timed alone.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (w_in_wait) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (w_tmo_hit) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign tmo_err = tmo_err_q;
`else
    // TMO_W has no role without the watchdog; keep the parameter referenced.
    logic [TMO_W-1:0] w_unused_tmo;
    logic             w_unused_wait;
    assign w_unused_tmo  = '0;
    assign w_unused_wait = w_in_wait;
    assign w_tmo_hit     = 1'b0;
    assign tmo_err       = 1'b0;
`endif

    assign mem_rd     = (state_q == S_FETCH);
    assign mem_addr   = addr_q;
    assign ld_go      = (state_q == S_GO);
    assign ld_stax    = stax_q;
    assign ld_stay    = stay_q;
    assign ld_endx    = endx_q;
    assign ld_endy    = endy_q;
    assign seq_busy   = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_vector_list_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_vector_list_seq
// Brief   : Self-checking bench for vector_list_seq (ADDR_W=3, TMO_W=4) with
//           sync-read memory and line drawer models. Honours VSEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vector_list_seq;

    localparam int AW = 3;
    localparam int NE = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [17:0]   mem_data;
    logic          ld_go;
    logic          ld_busy;
    logic [7:0]    ld_stax, ld_stay, ld_endx, ld_endy;
    logic          seq_busy, frame_done, tmo_err;

    always #5 clk = ~clk;

    vector_list_seq #(.ADDR_W(AW), .TMO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .ld_go(ld_go), .ld_busy(ld_busy),
        .ld_stax(ld_stax), .ld_stay(ld_stay), .ld_endx(ld_endx), .ld_endy(ld_endy),
        .seq_busy(seq_busy), .frame_done(frame_done), .tmo_err(tmo_err)
    );

    // Memory and drawer models
    logic [17:0] mem [NE];
    int          busy_len = 2;
    int          drw_cnt;

    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             drw_cnt <= 0;
        else if (ld_go)         drw_cnt <= busy_len;
        else if (drw_cnt != 0)  drw_cnt <= drw_cnt - 1;
    end
    assign ld_busy = (drw_cnt != 0);

    // Monitor
    logic [31:0] obs [$];
    logic [31:0] exp_q [$];
    logic [31:0] snap;
    int ndone, viol, rd0, maxaddr, nrd, first_addr, cyc, go_cyc, done_cyc;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (ld_go) begin
                snap = {ld_stax, ld_stay, ld_endx, ld_endy};
                obs.push_back(snap);
                go_cyc = cyc;
            end
            if (ld_busy && ({ld_stax, ld_stay, ld_endx, ld_endy} != snap)) viol++;
            if (mem_rd && ld_busy) viol++;
            if (mem_rd) begin
                if (nrd == 0) first_addr = int'(mem_addr);
                nrd++;
                if (mem_addr == 0) rd0++;
                if (int'(mem_addr) > maxaddr) maxaddr = int'(mem_addr);
            end
            if (frame_done) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [17:0] ent(input bit l, input bit m, input int x, input int y);
        logic [7:0] xb, yb;
        xb = x[7:0];
        yb = y[7:0];
        return {l, m, xb, yb};
    endfunction

    function automatic logic [31:0] ln(input int sx, input int sy, input int ex, input int ey);
        logic [7:0] a, b, c, d;
        a = sx[7:0]; b = sy[7:0]; c = ex[7:0]; d = ey[7:0];
        return {a, b, c, d};
    endfunction

    // Reference: pen tracking over the list, stopping at last or the final address
    function automatic void build_model();
        logic [7:0] cx, cy;
        bit first;
        first = 1'b1;
        cx = '0;
        cy = '0;
        exp_q.delete();
        for (int a = 0; a < NE; a++) begin
            if (!first && !mem[a][16]) exp_q.push_back({cx, cy, mem[a][15:8], mem[a][7:0]});
            first = 1'b0;
            cx = mem[a][15:8];
            cy = mem[a][7:0];
            if (mem[a][17]) break;
        end
    endfunction

    task automatic clear_mon();
        obs.delete();
        ndone = 0; viol = 0; rd0 = 0; maxaddr = 0; nrd = 0; first_addr = -1;
    endtask

    task automatic start_frame();
        clear_mon();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (ndone != 0) begin ok = 1'b1; break; end
        end
        check({nm, "_done_seen"}, 64'(ok), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_checks(input string nm);
        logic [63:0] act;
        check({nm, "_nlines"}, 64'(obs.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < obs.size()) ? {32'h0, obs[i]} : 64'hDEAD_0000_0000_0000;
            check($sformatf("%s_line%0d", nm, i), act, {32'h0, exp_q[i]});
        end
        check({nm, "_ndone"},   64'(ndone),    64'd1);
        check({nm, "_stable"},  64'(viol),     64'd0);
        check({nm, "_rd0"},     64'(rd0),      64'd1);
        check({nm, "_seqbusy"}, 64'(seq_busy), 64'd0);
    endtask

    typedef struct packed {
        logic [NE*18-1:0] ents;
        logic [3:0]       n;
        logic [7*32-1:0]  lines;
        logic [7:0]       busy;
    } vec_t;

    vec_t tbl [5];

    initial begin
        // Table of directed lists with hand-derived lines
        for (int k = 0; k < 5; k++) tbl[k] = '0;
        tbl[0].ents[0*18 +: 18] = ent(0, 1, 10, 10);
        tbl[0].ents[1*18 +: 18] = ent(0, 0, 20, 10);
        tbl[0].ents[2*18 +: 18] = ent(1, 0, 20, 30);
        tbl[0].n = 2;  tbl[0].busy = 3;
        tbl[0].lines[0 +: 32]  = ln(10, 10, 20, 10);
        tbl[0].lines[32 +: 32] = ln(20, 10, 20, 30);
        tbl[1].ents[0*18 +: 18] = ent(0, 0, 5, 5);
        tbl[1].ents[1*18 +: 18] = ent(1, 0, 9, 7);
        tbl[1].n = 1;  tbl[1].busy = 2;
        tbl[1].lines[0 +: 32] = ln(5, 5, 9, 7);
        tbl[2].ents[0*18 +: 18] = ent(0, 1, 1, 1);
        tbl[2].ents[1*18 +: 18] = ent(0, 0, 2, 2);
        tbl[2].ents[2*18 +: 18] = ent(1, 1, 3, 3);
        tbl[2].ents[3*18 +: 18] = ent(1, 0, 9, 9);
        tbl[2].n = 1;  tbl[2].busy = 1;
        tbl[2].lines[0 +: 32] = ln(1, 1, 2, 2);
        tbl[3].ents[0*18 +: 18] = ent(0, 1, 4, 4);
        tbl[3].ents[1*18 +: 18] = ent(1, 0, 4, 4);
        tbl[3].n = 1;  tbl[3].busy = 1;
        tbl[3].lines[0 +: 32] = ln(4, 4, 4, 4);
        for (int a = 0; a < NE; a++) tbl[4].ents[a*18 +: 18] = ent(0, 0, a * 3, 100 + a);
        for (int i = 1; i < NE; i++) tbl[4].lines[(i-1)*32 +: 32] = ln((i-1) * 3, 99 + i, i * 3, 100 + i);
        tbl[4].n = 7;  tbl[4].busy = 2;

        // Reset state
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset_outs_in_reset",
              {24'h0, mem_rd, mem_addr, ld_go, ld_stax, ld_stay, ld_endx, ld_endy, seq_busy, frame_done, tmo_err},
              64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outs_after",
              {24'h0, mem_rd, mem_addr, ld_go, ld_stax, ld_stay, ld_endx, ld_endy, seq_busy, frame_done, tmo_err},
              64'd0);

        for (int k = 0; k < 5; k++) begin
            for (int a = 0; a < NE; a++) mem[a] = tbl[k].ents[a*18 +: 18];
            exp_q.delete();
            for (int i = 0; i < int'(tbl[k].n); i++) exp_q.push_back(tbl[k].lines[i*32 +: 32]);
            busy_len = int'(tbl[k].busy);
            start_frame();
            wait_done($sformatf("tbl%0d", k), 400);
            frame_checks($sformatf("tbl%0d", k));
            check($sformatf("tbl%0d_maxaddr", k), 64'(maxaddr), (k == 4) ? 64'd7 : 64'(maxaddr <= 3 ? maxaddr : 99));
        end

        // Long drawer run with a frame_start pulse in the middle of a line
        mem[0] = ent(0, 1, 10, 10); mem[1] = ent(0, 0, 20, 10); mem[2] = ent(1, 0, 20, 30);
        build_model();
        busy_len = 40;
        start_frame();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ld_busy) break;
        end
        check("long_busy_seen", 64'(ld_busy), 64'd1);
        repeat (10) @(negedge clk);
        #1 frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        wait_done("long", 400);
        frame_checks("long");
        repeat (5) @(negedge clk);
        check("long_restart_ignored", 64'(seq_busy), 64'd0);

        // Asynchronous reset while waiting for the drawer to finish
        busy_len = 30;
        start_frame();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ld_busy) break;
        end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs",
              {24'h0, mem_rd, mem_addr, ld_go, ld_stax, ld_stay, ld_endx, ld_endy, seq_busy, frame_done, tmo_err},
              64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_done", 64'(ndone), 64'd0);
        busy_len = 3;
        start_frame();
        wait_done("arst_rerun", 400);
        frame_checks("arst_rerun");
        check("arst_first_addr", 64'(first_addr), 64'd0);

        // Randomized lists against the reference model
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < NE; a++)
                mem[a] = {($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom)};
            busy_len = int'($urandom_range(1, 6));
            build_model();
            start_frame();
            wait_done($sformatf("rnd%0d", it), 400);
            frame_checks($sformatf("rnd%0d", it));
        end

        // Drawer stuck busy
        mem[0] = ent(0, 1, 1, 2); mem[1] = ent(1, 0, 3, 4);
        busy_len = 100000;
`ifdef VSEQ_TIMEOUT_EN
        start_frame();
        wait_done("tmo", 200);
        check("tmo_err_set", 64'(tmo_err), 64'd1);
        check("tmo_ndone", 64'(ndone), 64'd1);
        check("tmo_latency", 64'(done_cyc - go_cyc), 64'd18);
        repeat (5) @(negedge clk);
        check("tmo_err_sticky", 64'(tmo_err), 64'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("tmo_err_cleared", 64'(tmo_err), 64'd0);
        rst_n = 1'b1;
`else
        start_frame();
        repeat (60) @(negedge clk);
        check("stuck_tmo_err", 64'(tmo_err), 64'd0);
        check("stuck_ndone", 64'(ndone), 64'd0);
        check("stuck_seqbusy", 64'(seq_busy), 64'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`endif
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
